// File: rtl/usb_cdc_tx_packer.sv
// usb_cdc_tx_packer
// Host-bound (IN) byte path for the USB CDC function. Bytes from fabric logic
// are buffered and written to the usb_fifo EP2 TX port in bursts of up to
// MAX_PKT bytes. A burst starts on a full packet, on a pending flush, or after
// an idle timeout. The idle timeout exists only when USB_CDC_TX_TIMEOUT_EN is
// defined; without it residual bytes wait for more data or an explicit flush.
// While the device is offline the buffer is held empty and every accepted
// byte is dropped and counted.
module usb_cdc_tx_packer #(
  parameter int DEPTH   = 256,
  parameter int MAX_PKT = 64,
  parameter int TIMEOUT = 60000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_online,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_flush,
  input  logic                   i_ep2_tx_ready,
  output logic                   o_ep2_tx_dval,
  output logic [7:0]             o_ep2_tx_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_busy,
  output logic [15:0]            o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] remaining;
  logic [LW-1:0] burst_len;
  logic          flush_pend;
  logic          wr_en, rd_en, trigger, burst_start, timeout_hit;
  logic          vld_p1;
  logic [7:0]    data_p1;
  logic [15:0]   drop_cnt;

  // Saturating increment for the drop counter: it sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Offline forces ready high so the source drains into the drop counter.
  assign o_ready   = (~i_online | (level < LW'(DEPTH))) & ~i_reset;
  assign wr_en     = i_valid & o_ready & i_online;
  assign burst_len = (level >= LW'(MAX_PKT)) ? LW'(MAX_PKT) : level;
  assign trigger   = i_online & ((level >= LW'(MAX_PKT)) |
                                 ((flush_pend | timeout_hit) & (level != '0)));

`ifdef USB_CDC_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  // Idle timer: counts IDLE cycles with data waiting, restarted by any write.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_online) begin
      idle_cnt <= '0;
    end else if (wr_en || burst_start || level == '0) begin
      idle_cnt <= '0;
    end else if (state == IDLE && idle_cnt != TW'(TIMEOUT - 1)) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign timeout_hit = (idle_cnt == TW'(TIMEOUT - 1));
`else
  // No idle timer in this build; the comparison keeps TIMEOUT referenced and
  // is constant false for any legal value.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // Next-state logic: IDLE waits for a trigger, BURST reads while EP2 is ready.
  always_comb begin
    state_nxt   = state;
    burst_start = 1'b0;
    rd_en       = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt   = BURST;
          burst_start = 1'b1;
        end
      end
      BURST: begin
        if (i_ep2_tx_ready && remaining != '0) begin
          rd_en = 1'b1;
          if (remaining == LW'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!i_online) begin
      state_nxt   = IDLE;
      burst_start = 1'b0;
      rd_en       = 1'b0;
    end
  end

  // State register and per-burst byte budget.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_online) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (burst_start) remaining <= burst_len;
      else if (rd_en) remaining <= remaining - LW'(1);
    end
  end

  // Flush request: cleared once a burst covers every buffered byte.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_online) begin
      flush_pend <= 1'b0;
    end else if (burst_start && burst_len == level) begin
      flush_pend <= 1'b0;
    end else if (i_flush && level != '0) begin
      flush_pend <= 1'b1;
    end
  end

  // Buffer pointers and fill level; going offline empties the buffer.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_online) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_en) - LW'(rd_en);
    end
  end

  // Buffer storage; contents need no reset because level gates every read.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

  // ---- stage p1: registered read data toward EP2 TX ----
  // Output register: byte appears one cycle after its read is issued.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= 8'h00;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) data_p1 <= mem[rd_ptr];
    end
  end

  // Drop counter: bytes accepted while offline.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      drop_cnt <= 16'h0000;
    end else if (!i_online && i_valid && o_ready) begin
      drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  assign o_ep2_tx_dval = vld_p1;
  assign o_ep2_tx_data = data_p1;
  assign o_level       = level;
  assign o_busy        = (state == BURST);
  assign o_drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_usb_cdc_tx_packer.sv
// Testbench for usb_cdc_tx_packer. A queue-based reference model follows the
// packer's rules each cycle (buffer contents, burst budget, flush request,
// drop count); a table of scenarios adds end-of-scenario expectations, and
// hand-written sequences cover full buffer, offline, reset and idle timeout.
// Honours USB_CDC_TX_TIMEOUT_EN the same way as the design.
module tb_usb_cdc_tx_packer;

  localparam int DEPTH   = 256;
  localparam int MAX_PKT = 64;
  localparam int TIMEOUT = 300;

  logic       clk = 1'b0;
  logic       rst, online, valid, flush, tx_ready;
  logic [7:0] din;
  logic       ready, dval, busy;
  logic [7:0] dout;
  logic [8:0] level;
  logic [15:0] drop;

  always #5 clk = ~clk;

  usb_cdc_tx_packer #(.DEPTH(DEPTH), .MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst), .i_online(online), .i_data(din),
    .i_valid(valid), .o_ready(ready), .i_flush(flush),
    .i_ep2_tx_ready(tx_ready), .o_ep2_tx_dval(dval), .o_ep2_tx_data(dout),
    .o_level(level), .o_busy(busy), .o_drop_cnt(drop)
  );

  int n_pass = 0;
  int n_total = 0;

  // reference model state (values after the most recent clock edge)
  logic [7:0] m_q[$];
  bit         m_burst = 0;
  int         m_rem = 0;
  bit         m_fpend = 0;
  bit         m_dval = 0;
  logic [7:0] m_data = 8'h00;
  int         m_drop = 0;
`ifdef USB_CDC_TX_TIMEOUT_EN
  int         m_tcnt = 0;
`endif

  // observation bookkeeping
  bit  chk_en = 0;
  bit  last_acc = 0;
  int  acc_cnt = 0;
  int  out_cnt = 0;
  int  rise_cnt = 0;
  int  cur_run = 0;
  int  max_run = 0;
  int  blens[$];
  bit  prev_busy = 0;
  int  rmode = 0;   // 0 ready high, 1 toggle, 2 random, 3 ready low

  typedef struct {
    int nbytes; bit do_flush; int rmode; int drain;
    int exp_out; int exp_bursts; int exp_level; int exp_run; int exp_first; int exp_last;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One clock cycle: drive tx_ready, compare at negedge, advance the model.
  task automatic step();
    int sz, blen;
    bit mready, acc, rd, trig, tout;
    case (rmode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = (($urandom % 2) == 1);
      default: tx_ready = 1'b0;
    endcase
    @(negedge clk);
    sz = m_q.size();
    mready = !rst && (!online || sz < DEPTH);
    if (chk_en) begin
      check("o_ready", int'(ready), int'(mready));
      check("o_level", int'(level), sz);
      check("o_busy", int'(busy), int'(m_burst));
      check("o_ep2_tx_dval", int'(dval), int'(m_dval));
      check("o_ep2_tx_data", int'(dout), int'(m_data));
      check("o_drop_cnt", int'(drop), m_drop);
    end
    if (busy && !prev_busy) begin rise_cnt++; blens.push_back(0); end
    prev_busy = busy;
    if (dval) begin
      out_cnt++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (blens.size() > 0) blens[blens.size()-1] = blens[blens.size()-1] + 1;
    end else begin
      cur_run = 0;
    end
    acc = !rst && valid && mready;
    last_acc = acc;
    if (rst) begin
      m_q.delete(); m_burst = 0; m_rem = 0; m_fpend = 0;
      m_dval = 0; m_data = 8'h00; m_drop = 0;
`ifdef USB_CDC_TX_TIMEOUT_EN
      m_tcnt = 0;
`endif
    end else if (!online) begin
      if (acc && m_drop < 65535) m_drop++;
      m_q.delete(); m_burst = 0; m_rem = 0; m_fpend = 0; m_dval = 0;
`ifdef USB_CDC_TX_TIMEOUT_EN
      m_tcnt = 0;
`endif
    end else begin
      tout = 0;
`ifdef USB_CDC_TX_TIMEOUT_EN
      tout = (m_tcnt == TIMEOUT - 1);
`endif
      rd   = m_burst && tx_ready && m_rem > 0;
      trig = !m_burst && (sz >= MAX_PKT || ((m_fpend || tout) && sz > 0));
      blen = (sz < MAX_PKT) ? sz : MAX_PKT;
      if (trig && blen == sz) m_fpend = 0;
      else if (flush && sz != 0) m_fpend = 1;
`ifdef USB_CDC_TX_TIMEOUT_EN
      if (acc || trig || sz == 0) m_tcnt = 0;
      else if (!m_burst && m_tcnt != TIMEOUT - 1) m_tcnt++;
`endif
      m_dval = rd;
      if (rd) m_data = m_q.pop_front();
      if (trig) begin
        m_burst = 1; m_rem = blen;
      end else if (rd) begin
        m_rem--;
        if (m_rem == 0) m_burst = 0;
      end
      if (acc) begin m_q.push_back(din); acc_cnt++; end
    end
    @(posedge clk);
    #1;
    chk_en = 1;
  endtask

  task automatic write_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      din = 8'($urandom);
      valid = 1'b1;
      do begin step(); guard++; end while (!last_acc && guard < 2000);
      check("write_accepted", int'(last_acc), 1);
    end
    valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!m_burst && m_q.size() == 0 && !m_dval) break;
      step();
    end
  endtask

  task automatic clear_obs();
    out_cnt = 0; rise_cnt = 0; cur_run = 0; max_run = 0; acc_cnt = 0;
    blens.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, last;
    vecs[0] = '{64,  1'b0, 0, 1500, 64,  1, 0, 64, 64, 64};
    vecs[1] = '{10,  1'b1, 0, 1500, 10,  1, 0, 10, 10, 10};
    vecs[2] = '{0,   1'b1, 0, 1500, 0,   0, 0, 0,  -1, -1};
    vecs[3] = '{150, 1'b1, 1, 1500, 150, 3, 0, 1,  64, 22};
    vecs[4] = '{100, 1'b1, 2, 1500, 100, 2, 0, -1, 64, 36};
    vecs[5] = '{5,   1'b0, 0, 150,  0,   0, 5, 0,  -1, -1};
    vecs[6] = '{59,  1'b0, 0, 1500, 64,  1, 0, 64, 64, 64};

    rst = 1'b1; online = 1'b1; valid = 1'b0; flush = 1'b0; tx_ready = 1'b0; din = 8'h00;
    #1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("reset_ready", int'(ready), 1);
    check("reset_level", int'(level), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_dval", int'(dval), 0);
    check("reset_data", int'(dout), 0);
    check("reset_drop", int'(drop), 0);

    // table-driven scenarios
    for (int i = 0; i < 7; i++) begin
      clear_obs();
      rmode = vecs[i].rmode;
      write_bytes(vecs[i].nbytes);
      if (vecs[i].do_flush) pulse_flush();
      drain(vecs[i].drain);
      repeat (4) step();
      check($sformatf("vec%0d_out_count", i), out_cnt, vecs[i].exp_out);
      check($sformatf("vec%0d_bursts", i), rise_cnt, vecs[i].exp_bursts);
      check($sformatf("vec%0d_level_end", i), int'(level), vecs[i].exp_level);
      if (vecs[i].exp_run >= 0)
        check($sformatf("vec%0d_max_run", i), max_run, vecs[i].exp_run);
      first = (blens.size() > 0) ? blens[0] : -1;
      last  = (blens.size() > 0) ? blens[blens.size()-1] : -1;
      check($sformatf("vec%0d_first_len", i), first, vecs[i].exp_first);
      check($sformatf("vec%0d_last_len", i), last, vecs[i].exp_last);
    end

    // full buffer with EP2 stalled, then writes resume as reads free space
    clear_obs();
    rmode = 3;
    write_bytes(256);
    check("full_level", int'(level), 256);
    check("full_ready", int'(ready), 0);
    rmode = 0;
    valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      din = 8'($urandom);
      step();
    end
    valid = 1'b0;
    pulse_flush();
    drain(2000);
    check("full_resumed", int'(acc_cnt > 256), 1);
    check("full_delivered", out_cnt, acc_cnt);
    check("full_level_end", int'(level), 0);

    // offline mid-burst, then dropped writes
    clear_obs();
    rmode = 0;
    write_bytes(64);
    n = 0;
    while (out_cnt < 20 && n < 300) begin step(); n++; end
    check("offline_20_sent", out_cnt, 20);
    online = 1'b0;
    step();
    check("offline_dval", int'(dval), 0);
    check("offline_level", int'(level), 0);
    check("offline_busy", int'(busy), 0);
    write_bytes(5);
    check("offline_drop_cnt", int'(drop), 5);
    online = 1'b1;
    step();

    // reset mid-burst
    clear_obs();
    write_bytes(64);
    n = 0;
    while (out_cnt < 5 && n < 300) begin step(); n++; end
    check("rstmid_5_sent", out_cnt, 5);
    rst = 1'b1;
    step();
    check("rstmid_level", int'(level), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_dval", int'(dval), 0);
    check("rstmid_data", int'(dout), 0);
    check("rstmid_drop", int'(drop), 0);
    check("rstmid_ready_in_reset", int'(ready), 0);
    rst = 1'b0;
    #1;
    check("rstmid_ready_after", int'(ready), 1);
    step();

    // idle timeout
    clear_obs();
    write_bytes(3);
`ifdef USB_CDC_TX_TIMEOUT_EN
    n = 0;
    while (!busy && n < 1000) begin step(); n++; end
    check("timeout_latency", n, TIMEOUT);
    drain(200);
    repeat (2) step();
    check("timeout_out_count", out_cnt, 3);
`else
    for (int i = 0; i < 2 * TIMEOUT; i++) step();
    check("no_timeout_bursts", rise_cnt, 0);
    check("no_timeout_out", out_cnt, 0);
    check("no_timeout_level", int'(level), 3);
    pulse_flush();
    drain(200);
    repeat (2) step();
    check("no_timeout_flush_out", out_cnt, 3);
`endif
    check("final_level", int'(level), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/usb_cdc_tx_packer.md
# usb_cdc_tx_packer

Host-bound (IN) path for the USB CDC function: accepts a byte stream from fabric logic, buffers it, and writes it into the endpoint-2 TX port of `usb_fifo` (`i_ep2_tx_dval`/`i_ep2_tx_data`) in packet-sized bursts. This is the complement of the EP2 OUT path that drives `usb_data_out`/`usb_data_valid_out`. It runs on `PHY_CLKOUT` (60 MHz) next to `usb_fifo`. Bursts are triggered by a full packet, an explicit flush, or an idle timeout.

## Interface
Parameters:
- `DEPTH`, 256: buffer depth in bytes; power of two, ≥ `MAX_PKT`.
- `MAX_PKT`, 64: maximum burst length in bytes; must match `i_ep2_tx_max`.
- `TIMEOUT`, 60000: idle cycles before an automatic flush (1 ms at 60 MHz).

Ports:
- `i_clk` in 1: clock (`PHY_CLKOUT`).
- `i_reset` in 1: reset, synchronous, active-high.
- `i_online` in 1: USB device configured/online.
- `i_data` in 8: input byte.
- `i_valid` in 1: `i_data` valid.
- `o_ready` out 1: the block accepts a byte this cycle.
- `i_flush` in 1: single-cycle request to send buffered bytes now.
- `i_ep2_tx_ready` in 1: the EP2 TX port can take a byte this cycle.
- `o_ep2_tx_dval` out 1: byte valid toward EP2 TX.
- `o_ep2_tx_data` out 8: byte toward EP2 TX.
- `o_level` out log2(DEPTH)+1: buffered byte count.
- `o_busy` out 1: a burst is in progress.
- `o_drop_cnt` out 16: count of bytes discarded while offline; saturates at 16'hFFFF.

## Operation
- **Input handshake:** a byte is written when `i_valid & o_ready`.
  - `o_ready = (o_level < DEPTH) & ~i_reset`, computed from registered state.
- **Offline:** while `i_online=0`:
  - The buffer is held empty and `o_ready=1`.
  - Each accepted byte is discarded and increments `o_drop_cnt`.
  - Flush and timeout state is cleared.
- **States:**
  - IDLE: waits for a burst trigger.
  - BURST: transfers bytes.
- **Burst trigger** (evaluated in IDLE):
  - `o_level ≥ MAX_PKT`, or
  - (`flush_pend` or timeout) and `o_level > 0`.
- **Burst start:** latch `burst_len = min(o_level, MAX_PKT)` and go to BURST.
  - `flush_pend` is cleared if `burst_len == o_level`; otherwise it stays set and the next burst follows.
- **BURST:**
  - Each cycle with `i_ep2_tx_ready=1` and `remaining > 0` issues one buffer read and decrements `remaining`.
  - When `remaining` reaches 0 and the last read is issued, return to IDLE.
- **Flush:** `i_flush` sets `flush_pend`.
  - If `o_level == 0` at that time, `flush_pend` is not set; no zero-length packet is sent.
- **Timeout counter:**
  - Increments in IDLE while `o_level > 0`.
  - Clears on any accepted write, on burst start, and whenever `o_level == 0`.
  - Reaching `TIMEOUT-1` is a trigger.
- **Simultaneous write and read:** permitted. `o_level` is unchanged; a full buffer accepts no write that cycle even if a read occurs.
- **Pointers:** log2(DEPTH) bits, natural wrap-around.
- **`i_online` falling:**
  - From IDLE: return to empty.
  - Mid-burst: abort to IDLE and empty the buffer.
  - `o_ep2_tx_dval` is 0 from the next cycle.

## Timing
- **Reset values:** `o_ep2_tx_dval=0`, `o_ep2_tx_data=8'h00`, `o_level=0`, `o_busy=0`, `o_drop_cnt=0`, state IDLE. `o_ready=1` on the first cycle after reset deasserts.
- **Write-to-level latency:** a write is visible in `o_level` 1 cycle later.
- **Burst trigger:** the IDLE→BURST transition occurs on the cycle after the trigger condition holds; `o_busy` is registered and high for the whole of BURST.
- **Read latency:** 1 cycle. `o_ep2_tx_dval`/`o_ep2_tx_data` are registered and assert one cycle after the read.
- With `i_ep2_tx_ready` held high, a `MAX_PKT` burst yields 64 consecutive `o_ep2_tx_dval` cycles.
- **`i_ep2_tx_ready` low:** pauses reads; no byte is lost or repeated.
- **Back-to-back bursts:** at least 1 IDLE cycle between consecutive bursts.
- **Reset mid-operation:** all state returns to reset values on the next edge; buffered data is discarded.

## Configuration
- Macro `USB_CDC_TX_TIMEOUT_EN`.
- **Defined:** the idle timeout counter and its trigger are present as specified.
- **Undefined:** the counter is removed. Bursts occur only on `o_level ≥ MAX_PKT` or `flush_pend`; residual bytes wait indefinitely for more data or `i_flush`.

## Test plan
- Online; write 64 bytes 0x00..0x3F back-to-back; `i_ep2_tx_ready=1` → one burst of 64 `o_ep2_tx_dval` cycles, data 0x00..0x3F in order; `o_level` returns to 0.
- Write 10 bytes, then pulse `i_flush` → a 10-byte burst. Pulse `i_flush` with an empty buffer → no `o_ep2_tx_dval`.
- Write 150 bytes and pulse `i_flush` once → bursts of 64, 64, 22. Toggle `i_ep2_tx_ready` every other cycle → same byte order, no duplicates.
- With the macro defined, write 3 bytes and idle → a 3-byte burst starts 60000 cycles after the last write. With the macro undefined → no burst after 120000 cycles.
- Fill 256 bytes while `i_ep2_tx_ready=0` → `o_ready=0` at `o_level=256`. Then hold `i_valid` and release ready → writes resume only as reads free space; total bytes delivered equals total bytes accepted.
- Drop `i_online` mid-burst after 20 bytes → `o_ep2_tx_dval=0` next cycle and `o_level=0`. Write 5 bytes while offline → `o_drop_cnt=5`. Assert `i_reset` mid-burst → all outputs at reset values.
